coin_intake_module: RTL and testbench
=====================================

// Module: coin_intake_module
// PURPOSE
//  Front end of the coffee machine credit path. Conditions the raw coin_100 / coin_500 push inputs.
//  Steps per input: 2-flop synchronise, debounce, then convert to a single accept event per insertion.
//  Accumulates credit in units of 100 (coin_100 = +1, coin_500 = +5), saturating at MAX_CREDIT.
//  total_coins feeds the coin comparator, coin display and subtractor stages.
//  credit_clear empties the credit once a drink is paid.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive stable synchronised cycles required to accept a level change (>=2)
//  MAX_CREDIT       10  credit ceiling in units of 100 (10 = 1000)
//  CREDIT_W         4   width of total_coins; must hold MAX_CREDIT
// PORTS
//  clock         in   1         system clock, all state on rising edge
//  reset         in   1         asynchronous, active-high; clears all state
//  coin_100      in   1         raw, asynchronous, bouncy level from 100 coin slot
//  coin_500      in   1         raw, asynchronous, bouncy level from 500 coin slot
//  credit_clear  in   1         1-cycle pulse: zero the credit (drink paid / refund done)
//  total_coins   out  CREDIT_W  accumulated credit, units of 100, registered
//  coin_pulse    out  1         1-cycle pulse: a coin was accepted into total_coins this edge
//  coin_rejected out  1         1-cycle pulse: an accepted insertion would exceed MAX_CREDIT; discarded
//  credit_full   out  1         registered, 1 when total_coins == MAX_CREDIT
// BEHAVIOUR
//  Reset (async assert, sync release): sync flops, debounce state, counters, total_coins = 0;
//    coin_pulse, coin_rejected, credit_full = 0.
//  Synchroniser: two flops per coin input; only the second-flop value (s) is used downstream.
//  Debounce FSM, one per input; counter cnt is 0..DEBOUNCE_CYCLES-1:
//    IDLE    : s=1 -> ARMING, cnt=1; else stay.
//    ARMING  : s=0 -> IDLE, cnt=0 (glitch dropped).
//              s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, raise the channel accept event for this edge.
//              Else cnt+1.
//    HELD    : s=0 -> RELEASING, cnt=1; else stay (held coin produces no further events).
//    RELEASING: s=1 -> HELD. s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. Else cnt+1.
//  Latency: raw input high and stable before edge k -> total_coins/coin_pulse update at edge k+2+DEBOUNCE_CYCLES.
//  Accumulate (registered): add = 1*acc100 + 5*acc500 (both in same cycle -> 6, one combined event).
//    Base value: base = credit_clear ? 0 : total_coins.
//    If add!=0 and base+add <= MAX_CREDIT: total_coins <= base+add; coin_pulse <= 1.
//    If add!=0 and base+add > MAX_CREDIT: total_coins <= base; coin_rejected <= 1 (whole event refused).
//    If add==0: total_coins <= base.
//    Computed at CREDIT_W+1 bits, no wrap.
//  credit_clear + accept in same cycle: clear applied first, coin not lost (total = coin value).
//  credit_full derived from next total_coins, registered alongside it.
//  Reset mid-debounce: in-flight event discarded.
//    A coin still high after reset release is counted as a new insertion after full latency.
// TESTING (DEBOUNCE_CYCLES=4, MAX_CREDIT=10)
//  T1: reset, coin_100 high 12 cycles -> coin_pulse at edge 6 after rise, total_coins=1, no 2nd pulse.
//  T2: coin_100 high 3 cycles then low (glitch), also 1-cycle bounces -> total_coins stays 0, no pulses.
//  T3: ten clean coin_100 insertions -> total_coins=10, credit_full=1.
//      11th insertion -> coin_rejected pulse, total_coins stays 10.
//  T4: total_coins=8, coin_500 -> coin_rejected, total 8; then credit_clear, coin_500 -> total_coins=5.
//  T5: total 0, coin_100 and coin_500 rise on same edge -> single coin_pulse, total_coins=6.
//      Then credit_clear coincident with next coin_100 accept -> total_coins=1.
//  T6: reset asserted async mid-ARMING with total 3 -> total_coins=0 immediately (before next edge).
//      Coin held across release -> total_coins=1 after 6 edges.

Source files
------------

// File: rtl/coin_intake_module.sv
// Coin slot front end: per-input synchroniser and debounce, one accept event per
// insertion, and a saturating credit accumulator in units of 100.
module coin_intake_module #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_CREDIT      = 10,
    parameter int CREDIT_W        = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_100,
    input  logic                coin_500,
    input  logic                credit_clear,
    output logic [CREDIT_W-1:0] total_coins,
    output logic                coin_pulse,
    output logic                coin_rejected,
    output logic                credit_full
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int SUM_W = CREDIT_W + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } db_state_t;

    logic [1:0] coin_raw;
    logic [1:0] acc;

    assign coin_raw = {coin_500, coin_100};

    // Channel 0 is the 100 slot, channel 1 the 500 slot.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic             sync1_reg;
            logic             sync2_reg;
            db_state_t        state_reg;
            db_state_t        state_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             acc_reg;
            logic             acc_next;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    acc_reg   <= 1'b0;
                end else begin
                    sync1_reg <= coin_raw[gi];
                    sync2_reg <= sync1_reg;
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    acc_reg   <= acc_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                acc_next   = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (sync2_reg) begin
                            state_next = ARMING;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                    ARMING: begin
                        if (!sync2_reg) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = HELD;
                            cnt_next   = '0;
                            acc_next   = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        // A coin that stays pressed never re-triggers.
                        if (!sync2_reg) begin
                            state_next = RELEASING;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                    RELEASING: begin
                        if (sync2_reg) begin
                            state_next = HELD;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            assign acc[gi] = acc_reg;
        end
    endgenerate

    logic [CREDIT_W-1:0] total_reg;
    logic [CREDIT_W-1:0] total_next;
    logic                pulse_reg;
    logic                pulse_next;
    logic                rejected_reg;
    logic                rejected_next;
    logic                full_reg;
    logic                full_next;
    logic [SUM_W-1:0]    base;
    logic [SUM_W-1:0]    add;
    logic [SUM_W-1:0]    sum;

    // Clear is applied before the add so a coin landing with the clear is kept.
    assign base = credit_clear ? '0 : {1'b0, total_reg};
    assign add  = SUM_W'(acc[0]) + (acc[1] ? SUM_W'(5) : '0);
    assign sum  = base + add;

    always_comb begin
        total_next    = base[CREDIT_W-1:0];
        pulse_next    = 1'b0;
        rejected_next = 1'b0;
        if (add != '0) begin
            if (sum <= SUM_W'(MAX_CREDIT)) begin
                total_next = sum[CREDIT_W-1:0];
                pulse_next = 1'b1;
            end else begin
                rejected_next = 1'b1;
            end
        end
        full_next = (total_next == CREDIT_W'(MAX_CREDIT));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            total_reg    <= '0;
            pulse_reg    <= 1'b0;
            rejected_reg <= 1'b0;
            full_reg     <= 1'b0;
        end else begin
            total_reg    <= total_next;
            pulse_reg    <= pulse_next;
            rejected_reg <= rejected_next;
            full_reg     <= full_next;
        end
    end

    assign total_coins   = total_reg;
    assign coin_pulse    = pulse_reg;
    assign coin_rejected = rejected_reg;
    assign credit_full   = full_reg;

endmodule

// File: tb/tb_coin_intake_module.sv
// Directed bench for coin_intake_module with DEBOUNCE_CYCLES=4, MAX_CREDIT=10.
module tb_coin_intake_module;

    logic       clock = 1'b0;
    logic       reset;
    logic       coin_100;
    logic       coin_500;
    logic       credit_clear;
    logic [3:0] total_coins;
    logic       coin_pulse;
    logic       coin_rejected;
    logic       credit_full;

    int checks = 0;
    int errors = 0;

    coin_intake_module #(
        .DEBOUNCE_CYCLES(4),
        .MAX_CREDIT     (10),
        .CREDIT_W       (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .coin_100     (coin_100),
        .coin_500     (coin_500),
        .credit_clear (credit_clear),
        .total_coins  (total_coins),
        .coin_pulse   (coin_pulse),
        .coin_rejected(coin_rejected),
        .credit_full  (credit_full)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ch: 0 = coin_100, 1 = coin_500, 2 = both. Coin held 12 cycles, then released.
    // Raw rises just after edge e; first sampling edge k=e+1; result visible after k+6.
    task automatic insert(input string tag, input int ch, input bit clr,
                          input int exp_pulse, input int exp_rej, input int exp_total);
        coin_100 = (ch != 1);
        coin_500 = (ch != 0);
        repeat (6) tick();
        check({tag, " early_pulse"}, coin_pulse, 0);
        check({tag, " early_rej"}, coin_rejected, 0);
        if (clr) credit_clear = 1'b1;
        tick();
        credit_clear = 1'b0;
        check({tag, " pulse"}, coin_pulse, exp_pulse);
        check({tag, " rejected"}, coin_rejected, exp_rej);
        check({tag, " total"}, total_coins, exp_total);
        $display("txn %s: total=%0d pulse=%0b rej=%0b full=%0b",
                 tag, total_coins, coin_pulse, coin_rejected, credit_full);
        tick();
        check({tag, " pulse_once"}, coin_pulse, 0);
        check({tag, " rej_once"}, coin_rejected, 0);
        repeat (4) tick();
        check({tag, " held_no_repeat"}, coin_pulse, 0);
        coin_100 = 1'b0;
        coin_500 = 1'b0;
        repeat (8) tick();
        check({tag, " total_after_release"}, total_coins, exp_total);
    endtask

    initial begin
        reset        = 1'b1;
        coin_100     = 1'b0;
        coin_500     = 1'b0;
        credit_clear = 1'b0;
        #2;
        check("reset total", total_coins, 0);
        check("reset pulse", coin_pulse, 0);
        check("reset rej", coin_rejected, 0);
        check("reset full", credit_full, 0);
        tick();
        do_reset();

        // T1: single clean insertion
        insert("T1", 0, 1'b0, 1, 0, 1);
        check("T1 full", credit_full, 0);

        // T2: 3-cycle glitch then 1-cycle bounces never accepted
        do_reset();
        coin_100 = 1'b1;
        repeat (3) tick();
        coin_100 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            coin_100 = 1'b1;
            tick();
            coin_100 = 1'b0;
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            check("T2 no_pulse", coin_pulse, 0);
        end
        check("T2 total", total_coins, 0);
        $display("txn T2: total=%0d after glitches", total_coins);

        // T3: fill to the ceiling, then overflow
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            insert($sformatf("T3 coin%0d", i), 0, 1'b0, 1, 0, i);
            check($sformatf("T3 full%0d", i), credit_full, (i == 10) ? 1 : 0);
        end
        insert("T3 coin11", 0, 1'b0, 0, 1, 10);
        check("T3 full_after_reject", credit_full, 1);

        // T4: 500 refused at 8, accepted after clear
        do_reset();
        insert("T4 500a", 1, 1'b0, 1, 0, 5);
        insert("T4 100a", 0, 1'b0, 1, 0, 6);
        insert("T4 100b", 0, 1'b0, 1, 0, 7);
        insert("T4 100c", 0, 1'b0, 1, 0, 8);
        insert("T4 500b", 1, 1'b0, 0, 1, 8);
        credit_clear = 1'b1;
        tick();
        credit_clear = 1'b0;
        check("T4 cleared", total_coins, 0);
        insert("T4 500c", 1, 1'b0, 1, 0, 5);

        // T5: simultaneous coins, then clear coincident with accept
        do_reset();
        insert("T5 both", 2, 1'b0, 1, 0, 6);
        insert("T5 clr_accept", 0, 1'b1, 1, 0, 1);

        // T6: async reset mid-ARMING, coin held through release
        do_reset();
        insert("T6 a", 0, 1'b0, 1, 0, 1);
        insert("T6 b", 0, 1'b0, 1, 0, 2);
        insert("T6 c", 0, 1'b0, 1, 0, 3);
        coin_100 = 1'b1;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        check("T6 async_total", total_coins, 0);
        check("T6 async_pulse", coin_pulse, 0);
        check("T6 async_full", credit_full, 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (6) tick();
        check("T6 early_total", total_coins, 0);
        check("T6 early_pulse", coin_pulse, 0);
        tick();
        check("T6 total", total_coins, 1);
        check("T6 pulse", coin_pulse, 1);
        $display("txn T6: total=%0d after reset release", total_coins);
        coin_100 = 1'b0;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
